// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART definitions (state encoding, widths, parity helper)
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int BAUD_CNT_W = 24;

    typedef logic [2:0] uart_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_sync.sv
// ============================================================================
// rx_sync : SYNC_STAGES-deep flop chain for the asynchronous RX line, resets high
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    // Reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rxuart_lite.sv
// ============================================================================
// rxuart_lite : 8N1 UART receiver with one-entry valid/ready output register
//               Optional even parity bit when RXUART_PARITY_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rxuart_lite
    import uart_pkg::*;
#(
    parameter logic [BAUD_CNT_W-1:0] CLOCKS_PER_BAUD = 24'd138,
    parameter int                    SYNC_STAGES     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_uart_rx,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_parity_err
);

    localparam logic [BAUD_CNT_W-1:0] HALF_BAUD_M1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
    localparam logic [BAUD_CNT_W-1:0] FULL_BAUD_M1 = CLOCKS_PER_BAUD - 24'd1;
    localparam logic [2:0]            LAST_BIT     = 3'(DATA_BITS - 1);

    logic                  rx_s;
    uart_state_t           state;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [2:0]            bit_idx;
    logic [DATA_BITS-1:0]  shift_data;
    logic                  commit_pend;
    logic                  baud_tick;

    rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .async_in (i_uart_rx),
        .sync_out (rx_s)
    );

    assign baud_tick = (baud_cnt == '0);

`ifdef RXUART_PARITY_EN
    logic parity_bit;
`else
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift_data  <= '0;
            commit_pend <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef RXUART_PARITY_EN
            parity_bit   <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            commit_pend <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef RXUART_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= HALF_BAUD_M1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else if (rx_s) begin
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= FULL_BAUD_M1;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else begin
                        shift_data[bit_idx] <= rx_s;
                        baud_cnt            <= FULL_BAUD_M1;
                        if (bit_idx == LAST_BIT) begin
`ifdef RXUART_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef RXUART_PARITY_EN
                ST_PARITY: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else begin
                        parity_bit <= rx_s;
                        baud_cnt   <= FULL_BAUD_M1;
                        state      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else if (!rx_s) begin
                        // Framing error wins over a parity mismatch.
                        o_frame_err <= 1'b1;
                        state       <= ST_BREAK;
                    end else begin
                        state <= ST_IDLE;
`ifdef RXUART_PARITY_EN
                        if (parity_bit != even_parity(shift_data)) begin
                            o_parity_err <= 1'b1;
                        end else begin
                            commit_pend <= 1'b1;
                        end
`else
                        commit_pend <= 1'b1;
`endif
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // shift_data is untouched until the next frame's first data sample,
    // so the commit can safely land one cycle after the stop sample.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (commit_pend) begin
                o_data    <= shift_data;
                o_valid   <= 1'b1;
                o_overrun <= o_valid && !i_ready;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rxuart_lite.sv
// ============================================================================
// tb_rxuart_lite : directed + randomized self-checking bench for rxuart_lite
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_rxuart_lite;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
`ifdef RXUART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Line drop to first visible commit: half bit + data/stop bits, plus the
    // synchronizer, the edge that loads the first sync flop and the commit register.
    localparam int LAT = CPB / 2 + (FRAME_BITS - 1) * CPB + SYNC + 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       ready = 1'b1;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         n_frame = 0;
    int         n_over = 0;
    int         n_par = 0;
    int         n_double = 0;
    logic       prev_accept = 1'b0;

    rxuart_lite #(
        .CLOCKS_PER_BAUD (24'd16),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_uart_rx    (uart_rx),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_data       (data),
        .o_frame_err  (frame_err),
        .o_overrun    (overrun),
        .o_parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && ready) begin
            got_q.push_back(data);
            got_cyc.push_back(cyc);
            if (prev_accept) n_double++;
        end
        prev_accept = valid && ready;
        if (frame_err)  n_frame++;
        if (overrun)    n_over++;
        if (parity_err) n_par++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        wait_cycles(CPB);
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RXUART_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) ; // no parity bit in this build
`endif
        send_bit(stop);
    endtask

    task automatic check_got(input string tag, input logic [7:0] exp_q[$]);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] hello[16];
        int         drop_cyc;
        int         f0, o0, p0;
        string      s;

        // Reset state
        reset_n = 1'b0;
        @(posedge clk); #1;
        wait_cycles(4);
        check("rst_valid", valid, 0);
        check("rst_data", data, 8'h00);
        check("rst_frame", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity", parity_err, 0);
        reset_n = 1'b1;
        wait_cycles(5);

        // Single clean byte with latency check
        got_q.delete(); got_cyc.delete();
        drop_cyc = cyc;
        send_frame(8'h48, 1'b1, 1'b0);
        idle(20);
        exp_q = '{8'h48};
        check_got("single", exp_q);
        if (got_cyc.size() > 0) check("single_latency", got_cyc[0] - drop_cyc, LAT);
        check("single_pulse_width", n_double, 0);

        // Back-to-back string, no idle gap
        s = "Hello, World! \n\r";
        for (int i = 0; i < 16; i++) hello[i] = s[i];
        got_q.delete(); f0 = n_frame; o0 = n_over; p0 = n_par;
        for (int i = 0; i < 16; i++) send_frame(hello[i], 1'b1, 1'b0);
        idle(20);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(hello[i]);
        check_got("hello", exp_q);
        check("hello_errs", (n_frame - f0) + (n_over - o0) + (n_par - p0), 0);

        // Short glitch on idle line
        got_q.delete(); f0 = n_frame;
        uart_rx = 1'b0;
        wait_cycles(5);
        idle(3 * CPB);
        check("glitch_nobyte", got_q.size(), 0);
        check("glitch_noerr", n_frame - f0, 0);

        // Bad stop bit then long break, then recovery
        got_q.delete(); f0 = n_frame;
        send_frame(8'h55, 1'b0, 1'b0);
        uart_rx = 1'b0;
        wait_cycles(40 * CPB);
        check("break_one_frame_err", n_frame - f0, 1);
        check("break_nobyte", got_q.size(), 0);
        idle(2 * CPB);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        exp_q = '{8'hA5};
        check_got("after_break", exp_q);

        // Overrun with consumer stalled
        got_q.delete(); o0 = n_over;
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        idle(40);
        check("stall_hold_data", data, 8'h11);
        check("stall_hold_valid", valid, 1);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(20);
        check("overrun_pulses", n_over - o0, 1);
        check("overrun_data", data, 8'h22);
        check("overrun_valid", valid, 1);
        ready = 1'b1;
        @(posedge clk); #1;
        check("accept_clears_valid", valid, 0);
        idle(5);

        // Reset in the middle of a data phase
        got_q.delete(); f0 = n_frame; p0 = n_par;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset_n = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        idle(8 * CPB);
        check("abort_nobyte", got_q.size(), 0);
        check("abort_noerr", (n_frame - f0) + (n_par - p0), 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);
        exp_q = '{8'h3C};
        check_got("after_abort", exp_q);
`ifdef RXUART_PARITY_EN
        got_q.delete(); p0 = n_par;
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(20);
        check("parity_err_pulse", n_par - p0, 1);
        check("parity_nobyte", got_q.size(), 0);
`endif

        // Randomized frames against the reference model
        got_q.delete(); exp_q.delete(); f0 = n_frame; o0 = n_over;
        begin
            int exp_frame = 0;
            for (int n = 0; n < 30; n++) begin
                logic [7:0] b;
                logic       good;
                b    = 8'($urandom);
                good = ($urandom_range(0, 5) != 0);
                send_frame(b, good, 1'b0);
                if (good) begin
                    exp_q.push_back(b);
                    idle($urandom_range(0, 20));
                end else begin
                    exp_frame++;
                    uart_rx = 1'b0;
                    wait_cycles($urandom_range(0, 3 * CPB));
                    idle(CPB + $urandom_range(0, 10));
                end
            end
            idle(20);
            check_got("random", exp_q);
            check("random_frame_errs", n_frame - f0, exp_frame);
            check("random_no_overrun", n_over - o0, 0);
        end
        check("valid_single_cycle", n_double, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
